// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vga_pkg
// Brief    : 640x480@60 timing constants, pipeline flag type, colour mapping.
// Revision : 1.0
// ============================================================================
package vga_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int CELL_W   = 80;
  localparam int CELL_H   = 60;
  localparam int PIPE_LAT = 3;

  localparam int H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int H_SYNC_START = H_ACTIVE + H_FP;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
  localparam int V_SYNC_START = V_ACTIVE + V_FP;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

  // Width-matched copies for direct comparison against the counters.
  localparam logic [9:0] HCNT_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] VCNT_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] HCNT_ACTIVE = 10'(H_ACTIVE);
  localparam logic [9:0] VCNT_ACTIVE = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START    = 10'(H_SYNC_START);
  localparam logic [9:0] HS_END      = 10'(H_SYNC_END);
  localparam logic [9:0] VS_START    = 10'(V_SYNC_START);
  localparam logic [9:0] VS_END      = 10'(V_SYNC_END);
  localparam logic [6:0] HSUB_LAST   = 7'(CELL_W - 1);
  localparam logic [5:0] VSUB_LAST   = 6'(CELL_H - 1);

  typedef struct packed {
    logic active;
    logic hsync_n;
    logic vsync_n;
    logic cursor_edge;
    logic origin;
  } vid_flags_t;

  localparam vid_flags_t FLAGS_IDLE = '{active: 1'b0, hsync_n: 1'b1, vsync_n: 1'b1,
                                        cursor_edge: 1'b0, origin: 1'b0};

  function automatic logic [11:0] code_to_rgb(input logic [2:0] c);
    return {{4{c[2]}}, {4{c[1]}}, {4{c[0]}}};
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_timing.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing
// Brief    : Line/frame counters with division-free cell tracking and raw flags.
// Revision : 1.0
// ============================================================================
module vga_timing
  import vga_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  output logic [3:0] o_hcell,
  output logic [6:0] o_hsub,
  output logic [3:0] o_vcell,
  output logic [5:0] o_vsub,
  output logic       o_active,
  output logic       o_hsync_n,
  output logic       o_vsync_n,
  output logic       o_origin
);

  logic [9:0] r_hcnt;
  logic [9:0] r_vcnt;
  logic [3:0] r_hcell;
  logic [6:0] r_hsub;
  logic [3:0] r_vcell;
  logic [5:0] r_vsub;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hcnt  <= '0;
      r_vcnt  <= '0;
      r_hcell <= '0;
      r_hsub  <= '0;
      r_vcell <= '0;
      r_vsub  <= '0;
    end else if (r_hcnt == HCNT_LAST) begin
      r_hcnt  <= '0;
      r_hcell <= '0;
      r_hsub  <= '0;
      if (r_vcnt == VCNT_LAST) begin
        r_vcnt  <= '0;
        r_vcell <= '0;
        r_vsub  <= '0;
      end else begin
        r_vcnt <= r_vcnt + 10'd1;
        if (r_vsub == VSUB_LAST) begin
          r_vsub  <= '0;
          r_vcell <= r_vcell + 4'd1;
        end else begin
          r_vsub <= r_vsub + 6'd1;
        end
      end
    end else begin
      r_hcnt <= r_hcnt + 10'd1;
      if (r_hsub == HSUB_LAST) begin
        r_hsub  <= '0;
        r_hcell <= r_hcell + 4'd1;
      end else begin
        r_hsub <= r_hsub + 7'd1;
      end
    end
  end

  assign o_hcell   = r_hcell;
  assign o_hsub    = r_hsub;
  assign o_vcell   = r_vcell;
  assign o_vsub    = r_vsub;
  assign o_active  = (r_hcnt < HCNT_ACTIVE) && (r_vcnt < VCNT_ACTIVE);
  assign o_hsync_n = !((r_hcnt >= HS_START) && (r_hcnt <= HS_END));
  assign o_vsync_n = !((r_vcnt >= VS_START) && (r_vcnt <= VS_END));
  assign o_origin  = (r_hcnt == 10'd0) && (r_vcnt == 10'd0);

endmodule
`default_nettype wire

// File: rtl/vga_scan.sv
`default_nettype none
// ============================================================================
// Module   : vga_scan
// Brief    : VGA scan-out of an 8x8 cell canvas with cursor-cell outline.
// Revision : 1.0
// ============================================================================
module vga_scan
  import vga_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] colorCode,
  input  logic [7:0] cursorX,
  input  logic [7:0] cursorY,
  output logic [7:0] rx,
  output logic [7:0] ry,
  output logic       hsync,
  output logic       vsync,
  output logic [3:0] r,
  output logic [3:0] g,
  output logic [3:0] b,
  output logic       frameStart
);

  logic [3:0] w_hcell;
  logic [6:0] w_hsub;
  logic [3:0] w_vcell;
  logic [5:0] w_vsub;
  logic       w_active;
  logic       w_hsync_n;
  logic       w_vsync_n;
  logic       w_origin;
  logic       w_on_border;
  logic       w_cursor_edge;
  vid_flags_t w_flags;

  vga_timing u_timing (
    .clk       (clk),
    .reset     (reset),
    .o_hcell   (w_hcell),
    .o_hsub    (w_hsub),
    .o_vcell   (w_vcell),
    .o_vsub    (w_vsub),
    .o_active  (w_active),
    .o_hsync_n (w_hsync_n),
    .o_vsync_n (w_vsync_n),
    .o_origin  (w_origin)
  );

  // Cursor values of 8+ never equal a visible cell index, so no outline is drawn.
  assign w_on_border   = (w_hsub == 7'd0) || (w_hsub == HSUB_LAST) ||
                         (w_vsub == 6'd0) || (w_vsub == VSUB_LAST);
  assign w_cursor_edge = w_active && w_on_border &&
                         ({4'd0, w_hcell} == cursorX) && ({4'd0, w_vcell} == cursorY);
  assign w_flags       = '{active: w_active, hsync_n: w_hsync_n, vsync_n: w_vsync_n,
                           cursor_edge: w_cursor_edge, origin: w_origin};

  // Two flag stages plus the output register give the full pipeline latency.
  vid_flags_t r_dly [PIPE_LAT-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      rx         <= '0;
      ry         <= '0;
      for (int i = 0; i < PIPE_LAT - 1; i++) r_dly[i] <= FLAGS_IDLE;
      hsync      <= 1'b1;
      vsync      <= 1'b1;
      {r, g, b}  <= '0;
      frameStart <= 1'b0;
    end else begin
      rx       <= w_active ? {4'd0, w_hcell} : 8'd0;
      ry       <= w_active ? {4'd0, w_vcell} : 8'd0;
      r_dly[0] <= w_flags;
      for (int i = 1; i < PIPE_LAT - 1; i++) r_dly[i] <= r_dly[i-1];
      hsync      <= r_dly[PIPE_LAT-2].hsync_n;
      vsync      <= r_dly[PIPE_LAT-2].vsync_n;
      frameStart <= r_dly[PIPE_LAT-2].origin;
      if (!r_dly[PIPE_LAT-2].active)
        {r, g, b} <= 12'h000;
      else if (r_dly[PIPE_LAT-2].cursor_edge)
        {r, g, b} <= 12'hFFF;
      else
        {r, g, b} <= code_to_rgb(colorCode);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vga_scan.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_scan
// Brief    : Cycle-exact checks of vga_scan against a pixel-arithmetic model.
// Revision : 1.0
// ============================================================================
module tb_vga_scan;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] colorCode;
  logic [7:0] cursorX;
  logic [7:0] cursorY;
  logic [7:0] rx;
  logic [7:0] ry;
  logic       hsync;
  logic       vsync;
  logic [3:0] r;
  logic [3:0] g;
  logic [3:0] b;
  logic       frameStart;

  int n_vec = 0;
  int n_err = 0;

  logic [2:0] mem [0:7][0:7];
  logic [7:0] hx [0:3];
  logic [7:0] hy [0:3];

  always #5 clk = ~clk;

  vga_scan dut (
    .clk        (clk),
    .reset      (reset),
    .colorCode  (colorCode),
    .cursorX    (cursorX),
    .cursorY    (cursorY),
    .rx         (rx),
    .ry         (ry),
    .hsync      (hsync),
    .vsync      (vsync),
    .r          (r),
    .g          (g),
    .b          (b),
    .frameStart (frameStart)
  );

  // pixelStore stand-in: registered read, one cycle behind rx/ry.
  always @(posedge clk) colorCode <= mem[ry[2:0]][rx[2:0]];

  task automatic chk(input string tag, input int p, input logic [11:0] obs, input logic [11:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, p, obs, exp);
    end
  endtask

  // p counts cycles since the counters were last at (0,0) after reset.
  task automatic check_cycle(input int p);
    int k, h, v;
    logic [7:0]  e_rx, e_ry;
    logic [11:0] e_rgb;
    logic        e_hs, e_vs, e_fs;
    logic [2:0]  c;
    e_rx = 8'd0; e_ry = 8'd0;
    if (p >= 1) begin
      k = p - 1; h = k % 800; v = (k / 800) % 525;
      if (h < 640 && v < 480) begin
        e_rx = 8'(h / 80);
        e_ry = 8'(v / 60);
      end
    end
    e_rgb = 12'h000; e_hs = 1'b1; e_vs = 1'b1; e_fs = 1'b0;
    if (p >= 3) begin
      k = p - 3; h = k % 800; v = (k / 800) % 525;
      e_hs = !(h >= 656 && h < 752);
      e_vs = !(v >= 490 && v < 492);
      e_fs = (h == 0 && v == 0);
      if (h < 640 && v < 480) begin
        if ((h / 80) == int'(hx[k % 4]) && (v / 60) == int'(hy[k % 4]) &&
            (h % 80 == 0 || h % 80 == 79 || v % 60 == 0 || v % 60 == 59))
          e_rgb = 12'hFFF;
        else begin
          c = mem[v / 60][h / 80];
          e_rgb = {{4{c[2]}}, {4{c[1]}}, {4{c[0]}}};
        end
      end
    end
    chk("rx", p, {4'd0, rx}, {4'd0, e_rx});
    chk("ry", p, {4'd0, ry}, {4'd0, e_ry});
    chk("rgb", p, {r, g, b}, e_rgb);
    chk("hsync", p, {11'd0, hsync}, {11'd0, e_hs});
    chk("vsync", p, {11'd0, vsync}, {11'd0, e_vs});
    chk("frameStart", p, {11'd0, frameStart}, {11'd0, e_fs});
  endtask

  task automatic fill_mem();
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 8; x++)
        mem[y][x] = 3'($urandom_range(0, 7));
    mem[1][2] = 3'b101;
  endtask

  task automatic fill_hist();
    for (int i = 0; i < 4; i++) begin
      hx[i] = cursorX;
      hy[i] = cursorY;
    end
  endtask

  task automatic run(input int ncyc);
    for (int p = 0; p < ncyc; p++) begin
      check_cycle(p);
      if (p % 3000 == 1500) begin
        cursorX = 8'($urandom_range(0, 9));
        cursorY = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(8, 255))
                                              : 8'($urandom_range(0, 1));
      end
      hx[p % 4] = cursorX;
      hy[p % 4] = cursorY;
      @(negedge clk);
    end
  endtask

  initial begin
    reset   = 1'b1;
    cursorX = 8'd1;
    cursorY = 8'd0;
    fill_mem();
    fill_hist();
    repeat (5) begin
      @(posedge clk);
      @(negedge clk);
      check_cycle(0);
    end
    reset = 1'b0;
    run(8700);

    // Counters at (700,10): hsync is mid-pulse when reset lands.
    check_cycle(8700);
    reset = 1'b1;
    @(negedge clk);
    check_cycle(0);
    fill_mem();
    cursorX = 8'($urandom_range(0, 7));
    cursorY = 8'd0;
    fill_hist();
    repeat (2) begin
      @(negedge clk);
      check_cycle(0);
    end
    reset = 1'b0;
    run(49700);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
